// File: rtl/dvi_pkg.sv
// Shared TMDS receive definitions: control tokens, FSM states, symbol width.
// Used by tmds_symbol_decode and tmds_channel_decoder.
package dvi_pkg;

    localparam int SYM_W = 10;

    localparam logic [SYM_W-1:0] TOK_00 = 10'h354;
    localparam logic [SYM_W-1:0] TOK_01 = 10'h0AB;
    localparam logic [SYM_W-1:0] TOK_10 = 10'h154;
    localparam logic [SYM_W-1:0] TOK_11 = 10'h2AB;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Number of adjacent-bit transitions in a byte (0..7).
    function automatic logic [2:0] transitions(input logic [7:0] b);
        logic [2:0] n;
        n = '0;
        for (int i = 1; i < 8; i++) begin
            n = n + {2'b00, b[i] ^ b[i-1]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational decode of one aligned 10-bit TMDS symbol.
// The illegal flag exists only when TMDS_ERR_CNT_EN is defined.
module tmds_symbol_decode
    import dvi_pkg::*;
(
    input  logic [SYM_W-1:0] sym,
    output logic [7:0]       data,
    output logic [1:0]       ctrl,
    output logic             is_token
`ifdef TMDS_ERR_CNT_EN
    ,
    output logic             illegal
`endif
);

    logic [7:0] v;
    logic [7:0] dec;

    // Undo the optional inversion and XOR/XNOR chain, then spot tokens.
    always_comb begin
        v = sym[9] ? ~sym[7:0] : sym[7:0];
        dec = '0;
        dec[0] = v[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = sym[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
        end
        is_token = 1'b1;
        ctrl = 2'b00;
        unique case (sym)
            TOK_00:  ctrl = 2'b00;
            TOK_01:  ctrl = 2'b01;
            TOK_10:  ctrl = 2'b10;
            TOK_11:  ctrl = 2'b11;
            default: is_token = 1'b0;
        endcase
        data = is_token ? 8'h00 : dec;
    end

`ifdef TMDS_ERR_CNT_EN
    // Legal TMDS data never toggles more than four times within q[7:0].
    always_comb begin
        illegal = !is_token && (transitions(sym[7:0]) > 3'd4);
    end
`endif

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS channel receiver: bit-slip alignment search, lock FSM, decode.
// Define TMDS_ERR_CNT_EN to add the illegal-symbol counter err_cnt.
module tmds_channel_decoder
    import dvi_pkg::*;
#(
    parameter int CTRL_RUN      = 8,
    parameter int SEARCH_WINDOW = 2048,
    parameter int LOSS_TIMEOUT  = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SYM_W-1:0] raw_in,
    output logic [7:0]       data_out,
    output logic [1:0]       ctrl_out,
    output logic             de_out,
    output logic             locked,
    output logic [3:0]       offset
`ifdef TMDS_ERR_CNT_EN
    ,
    output logic [15:0]      err_cnt
`endif
);

    localparam int RUN_W = (CTRL_RUN > 1) ? $clog2(CTRL_RUN) : 1;
    localparam int DW_W  = (SEARCH_WINDOW > 1) ? $clog2(SEARCH_WINDOW) : 1;
    localparam int SC_W  = (LOSS_TIMEOUT > 1) ? $clog2(LOSS_TIMEOUT) : 1;

    localparam logic [RUN_W-1:0] RUN_LAST   = RUN_W'(CTRL_RUN - 1);
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(SEARCH_WINDOW - 1);
    localparam logic [SC_W-1:0]  SINCE_LAST = SC_W'(LOSS_TIMEOUT - 1);

    logic [SYM_W-1:0]   prev;
    logic [SYM_W-1:0]   aligned;
    logic [2*SYM_W-1:0] window;
    logic [4:0]         sel;

    logic [7:0] dec_data;
    logic [1:0] dec_ctrl;
    logic       tok;
`ifdef TMDS_ERR_CNT_EN
    logic       illegal;
`endif

    state_t           state, state_n;
    logic [3:0]       offset_n;
    logic [DW_W-1:0]  dwell, dwell_n;
    logic [RUN_W-1:0] run, run_n;
    logic [SC_W-1:0]  since, since_n;
    logic             gate;

    assign window = {raw_in, prev};
    assign sel    = {1'b0, offset};
    assign locked = (state == LOCKED);
    // Only ungate once locked, and drop in the same edge lock is lost.
    assign gate   = (state == LOCKED) && (state_n == LOCKED);

    // Two-stage front end: word history, then barrel select at offset.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev    <= '0;
            aligned <= '0;
        end else begin
            prev    <= raw_in;
            aligned <= window[sel +: SYM_W];
        end
    end

    tmds_symbol_decode u_dec (
        .sym      (aligned),
        .data     (dec_data),
        .ctrl     (dec_ctrl),
        .is_token (tok)
`ifdef TMDS_ERR_CNT_EN
        ,
        .illegal  (illegal)
`endif
    );

    // FSM state, bit-slip offset and the run/dwell/timeout counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= SEARCH;
            offset <= 4'd0;
            dwell  <= '0;
            run    <= '0;
            since  <= '0;
        end else begin
            state  <= state_n;
            offset <= offset_n;
            dwell  <= dwell_n;
            run    <= run_n;
            since  <= since_n;
        end
    end

    // Next state: a token run locks; a full dwell slips one bit.
    always_comb begin
        state_n  = state;
        offset_n = offset;
        dwell_n  = dwell;
        run_n    = run;
        since_n  = since;
        unique case (state)
            SEARCH: begin
                since_n = '0;
                dwell_n = dwell + 1'b1;
                run_n   = tok ? run + 1'b1 : '0;
                if (tok && (run == RUN_LAST)) begin
                    state_n = LOCKED;
                    dwell_n = '0;
                    run_n   = '0;
                end else if (dwell == DWELL_LAST) begin
                    offset_n = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
                    dwell_n  = '0;
                    run_n    = '0;
                end
            end
            LOCKED: begin
                since_n = tok ? '0 : since + 1'b1;
                if (!tok && (since == SINCE_LAST)) begin
                    state_n = SEARCH;
                    since_n = '0;
                    dwell_n = '0;
                    run_n   = '0;
                end
            end
        endcase
    end

    // Output registers; ctrl_out keeps its value across data periods.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= 8'h00;
            ctrl_out <= 2'b00;
            de_out   <= 1'b0;
        end else if (!gate) begin
            data_out <= 8'h00;
            ctrl_out <= 2'b00;
            de_out   <= 1'b0;
        end else if (tok) begin
            data_out <= 8'h00;
            ctrl_out <= dec_ctrl;
            de_out   <= 1'b0;
        end else begin
            data_out <= dec_data;
            de_out   <= 1'b1;
        end
    end

`ifdef TMDS_ERR_CNT_EN
    // Saturating count of illegal data symbols seen while locked.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= 16'h0000;
        end else if (locked && (state_n == SEARCH)) begin
            err_cnt <= 16'h0000;
        end else if (locked && illegal && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'h0001;
        end
    end
`endif

endmodule
